// File: rtl/crc8_pkg.sv
// Shared types and constants for the serial CRC-8 engine.
// Optional checker ports are enabled by CRC8_CHECK_EN.
package crc8_pkg;

  localparam int CRC_W = 8;

  localparam logic [CRC_W-1:0] CRC8_POLY_DEFAULT = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/crc8_step.sv
// One-bit MSB-first CRC-8 update, purely combinational.
// Shared by the serial engine for both frame start and shifting.
module crc8_step
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  assign fb = crc_in[CRC_W-1] ^ bit_in;

  assign crc_next = {crc_in[CRC_W-2:0], 1'b0}
                  ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc8_serial.sv
// Serial CRC-8 engine with framing, overrun guard and done pulse.
// Define CRC8_CHECK_EN to add the crc_ref input and crc_err output.
module crc8_serial
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY     = CRC8_POLY_DEFAULT,
  parameter logic [CRC_W-1:0] INIT     = 8'h00,
  parameter int               MAX_BITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid,
  output logic             busy,
  output logic             overrun
`ifdef CRC8_CHECK_EN
  ,
  input  logic [CRC_W-1:0] crc_ref,
  output logic             crc_err
`endif
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CRC_W-1:0] crc_r;
  logic [CRC_W-1:0] crc_nx;
  logic [CRC_W-1:0] step_in;
  logic [CRC_W-1:0] step_out;
  logic             ovr_r;
  logic             ovr_nx;
  logic             restart;
  logic             at_max;

  // DONE ignores everything, so a start there is not a restart
  assign restart = bit_valid && frame_start
                && (state != ST_DONE);
  assign at_max  = (bit_cnt == CNT_MAX);
  assign step_in = restart ? INIT : crc_r;

  crc8_step #(
    .POLY(POLY)
  ) u_step (
    .crc_in  (step_in),
    .bit_in  (bit_in),
    .crc_next(step_out)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    crc_nx   = crc_r;
    ovr_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (restart) begin
          crc_nx   = step_out;
          cnt_nx   = CNT_ONE;
          state_nx = frame_end ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          unique case (1'b1)
            frame_start: begin
              crc_nx   = step_out;
              cnt_nx   = CNT_ONE;
              state_nx = frame_end ? ST_DONE : ST_SHIFT;
            end
            (!frame_start && at_max): begin
              ovr_nx   = 1'b1;
              cnt_nx   = '0;
              state_nx = ST_IDLE;
            end
            (!frame_start && !at_max): begin
              crc_nx   = step_out;
              cnt_nx   = bit_cnt + CNT_ONE;
              state_nx = frame_end ? ST_DONE : ST_SHIFT;
            end
          endcase
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      crc_r   <= INIT;
      ovr_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      crc_r   <= crc_nx;
      ovr_r   <= ovr_nx;
    end
  end

  assign crc_out   = crc_r;
  assign crc_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign overrun   = ovr_r;

`ifdef CRC8_CHECK_EN
  logic err_nx;

  // reference is compared against the final value on the frame_end bit
  assign err_nx = (state_nx == ST_DONE)
               && (state != ST_DONE)
               && (step_out != crc_ref);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_err <= 1'b0;
    end else begin
      crc_err <= err_nx;
    end
  end
`endif

endmodule
